// File: rtl/wb_write_sequencer_if.sv
// rtl/wb_write_sequencer_if.sv - request, register-file write and forwarding signals of the write-back sequencer
interface wb_write_sequencer_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_data;
  logic              pc_save_valid;
  logic              pc_save_ready;
  logic [31:0]       pc_save_value;
  logic              write_enable;
  logic [ADDR_W-1:0] write_addr;
  logic [DATA_W-1:0] write_data;
  logic [ADDR_W-1:0] fwd_addr;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;

  // Sequencer side: accepts requests, drives the register-file write port and forwarding result
  modport master (
    input  in_valid, in_addr, in_data, pc_save_valid, pc_save_value, fwd_addr,
    output in_ready, pc_save_ready, write_enable, write_addr, write_data, fwd_hit, fwd_data
  );

  // Producer / register-file side
  modport slave (
    output in_valid, in_addr, in_data, pc_save_valid, pc_save_value, fwd_addr,
    input  in_ready, pc_save_ready, write_enable, write_addr, write_data, fwd_hit, fwd_data
  );
endinterface

// File: rtl/wb_write_sequencer.sv
// rtl/wb_write_sequencer.sv - queues result writes and PC saves, drains one register write per cycle
module wb_write_sequencer #(
  parameter int DEPTH      = 4,
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 4,
  parameter int PC_LO_ADDR = 9,
  parameter int PC_HI_ADDR = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         wb_stall,
  wb_write_sequencer_if.master         bus,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [ADDR_W-1:0] mem_addr_q [DEPTH];
  logic [ADDR_W-1:0] mem_addr_d [DEPTH];
  logic [DATA_W-1:0] mem_data_q [DEPTH];
  logic [DATA_W-1:0] mem_data_d [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic              in_ready_c;
  logic              pc_ready_c;
  logic              in_accept;
  logic              pc_accept;
  logic              pop;
  logic [CNT_W-1:0]  push_n;
  logic              fwd_hit_c;
  logic [DATA_W-1:0] fwd_data_c;
  logic [PTR_W-1:0]  fwd_idx;

  // Wrap-around increment; works for any DEPTH, not only powers of two
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Readiness from registered count only; a PC save blocks a same-cycle result write
  always_comb begin
    in_ready_c = !flush && !bus.pc_save_valid && (count_q <= CNT_W'(DEPTH-1));
    pc_ready_c = !flush && (count_q <= CNT_W'(DEPTH-2));
    in_accept  = bus.in_valid && in_ready_c;
    pc_accept  = bus.pc_save_valid && pc_ready_c;
    pop        = (count_q != '0) && !wb_stall && !flush;
    push_n     = pc_accept ? CNT_W'(2) : (in_accept ? CNT_W'(1) : '0);
  end

  // Next state of queue, pointers and output register; flush discards everything this cycle
  always_comb begin
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (pop) begin
        we_d    = 1'b1;
        waddr_d = mem_addr_q[head_q];
        wdata_d = mem_data_q[head_q];
        head_d  = ptr_inc(head_q);
      end
      if (pc_accept) begin
        mem_addr_d[tail_q]          = ADDR_W'(PC_LO_ADDR);
        mem_data_d[tail_q]          = bus.pc_save_value[15:0];
        mem_addr_d[ptr_inc(tail_q)] = ADDR_W'(PC_HI_ADDR);
        mem_data_d[ptr_inc(tail_q)] = bus.pc_save_value[31:16];
        tail_d                      = ptr_inc(ptr_inc(tail_q));
      end else if (in_accept) begin
        mem_addr_d[tail_q] = bus.in_addr;
        mem_data_d[tail_q] = bus.in_data;
        tail_d             = ptr_inc(tail_q);
      end
      count_d = count_q + push_n - CNT_W'(pop);
    end
  end

  // Forwarding: output register first, then queue oldest to youngest so the youngest match wins
  always_comb begin
    fwd_hit_c  = 1'b0;
    fwd_data_c = '0;
    fwd_idx    = head_q;
    if (we_q && (waddr_q == bus.fwd_addr)) begin
      fwd_hit_c  = 1'b1;
      fwd_data_c = wdata_q;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if ((CNT_W'(i) < count_q) && (mem_addr_q[fwd_idx] == bus.fwd_addr)) begin
        fwd_hit_c  = 1'b1;
        fwd_data_c = mem_data_q[fwd_idx];
      end
      fwd_idx = ptr_inc(fwd_idx);
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_addr_q[i] <= '0;
        mem_data_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign bus.in_ready      = in_ready_c;
  assign bus.pc_save_ready = pc_ready_c;
  assign bus.write_enable  = we_q;
  assign bus.write_addr    = waddr_q;
  assign bus.write_data    = wdata_q;
  assign bus.fwd_hit       = fwd_hit_c;
  assign bus.fwd_data      = fwd_data_c;
  assign count             = count_q;
  assign empty             = (count_q == '0);

endmodule

// File: tb/tb_wb_write_sequencer.sv
// tb/tb_wb_write_sequencer.sv - scoreboard bench for wb_write_sequencer
module tb_wb_write_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       wb_stall;
  logic [2:0] count;
  logic       empty;

  int n_checks = 0;
  int n_pass   = 0;
  logic [19:0] exp_q [$];

  wb_write_sequencer_if #(.DATA_W(16), .ADDR_W(4)) bus ();

  wb_write_sequencer #(
    .DEPTH(4), .DATA_W(16), .ADDR_W(4), .PC_LO_ADDR(9), .PC_HI_ADDR(10)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .wb_stall (wb_stall),
    .bus      (bus.master),
    .count    (count),
    .empty    (empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, expv);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic expect_wr(input logic [3:0] a, input logic [15:0] d);
    exp_q.push_back({a, d});
  endtask

  // Present one result write; the bench knows the queue has room, so it is accepted this cycle
  task automatic send(input logic [3:0] a, input logic [15:0] d);
    bus.in_valid = 1'b1;
    bus.in_addr  = a;
    bus.in_data  = d;
    neg();
    chk("send_in_ready", bus.in_ready, 1);
    expect_wr(a, d);
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Monitor: every register-file write must be the oldest expected one
  always @(negedge clk) begin
    if (rst && bus.write_enable) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL wr_unexpected: got addr %0d data %h, required no write", bus.write_addr, bus.write_data);
      end else begin
        logic [19:0] e;
        e = exp_q.pop_front();
        chk("wr_order", {12'h0, bus.write_addr, bus.write_data}, {12'h0, e});
      end
    end
  end

  initial begin
    #50000;
    n_checks++;
    $display("FAIL timeout: got no end of test, required finish");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    rst = 1'b0;
    flush = 1'b0;
    wb_stall = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_addr = '0;
    bus.in_data = '0;
    bus.pc_save_valid = 1'b0;
    bus.pc_save_value = '0;
    bus.fwd_addr = '0;
    tick();
    chk("rst_we", bus.write_enable, 0);
    chk("rst_waddr", bus.write_addr, 0);
    chk("rst_wdata", bus.write_data, 0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_fwd_hit", bus.fwd_hit, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    tick();
    rst = 1'b1;
    tick();

    // Single write latency
    bus.in_valid = 1'b1; bus.in_addr = 4'd3; bus.in_data = 16'h1234;
    neg();
    chk("single_in_ready", bus.in_ready, 1);
    expect_wr(4'd3, 16'h1234);
    tick();
    bus.in_valid = 1'b0;
    neg();
    chk("single_we_n", bus.write_enable, 0);
    chk("single_count_n", count, 1);
    tick();
    neg();
    chk("single_we_n1", bus.write_enable, 1);
    chk("single_waddr", bus.write_addr, 3);
    chk("single_wdata", bus.write_data, 16'h1234);
    chk("single_count_n1", count, 0);
    tick();
    neg();
    chk("single_we_n2", bus.write_enable, 0);
    chk("single_empty", empty, 1);

    // PC save has priority over a same-cycle result write
    tick();
    bus.pc_save_valid = 1'b1; bus.pc_save_value = 32'h0001_ABCD;
    bus.in_valid = 1'b1; bus.in_addr = 4'd7; bus.in_data = 16'h7777;
    neg();
    chk("pc_in_ready", bus.in_ready, 0);
    chk("pc_ready", bus.pc_save_ready, 1);
    expect_wr(4'd9, 16'hABCD);
    expect_wr(4'd10, 16'h0001);
    tick();
    bus.pc_save_valid = 1'b0;
    neg();
    chk("pc_count", count, 2);
    chk("pc_in_ready_after", bus.in_ready, 1);
    expect_wr(4'd7, 16'h7777);
    tick();
    bus.in_valid = 1'b0;
    neg();
    chk("pc_lo", {bus.write_enable, bus.write_addr, bus.write_data}, {1'b1, 4'd9, 16'hABCD});
    tick();
    neg();
    chk("pc_hi", {bus.write_enable, bus.write_addr, bus.write_data}, {1'b1, 4'd10, 16'h0001});
    tick();
    neg();
    chk("pc_res", {bus.write_enable, bus.write_addr, bus.write_data}, {1'b1, 4'd7, 16'h7777});
    tick();
    neg();
    chk("pc_done_empty", empty, 1);

    // Full under stall, then ordered drain
    tick();
    wb_stall = 1'b1;
    for (int i = 1; i <= 4; i++) send(4'(i), 16'(16'hA0 + i));
    neg();
    chk("full_count", count, 4);
    chk("full_in_ready", bus.in_ready, 0);
    chk("full_pc_ready", bus.pc_save_ready, 0);
    chk("full_we", bus.write_enable, 0);
    tick();
    bus.in_valid = 1'b1; bus.in_addr = 4'd15; bus.in_data = 16'hFFFF;
    bus.pc_save_valid = 1'b1; bus.pc_save_value = 32'hDEAD_BEEF;
    neg();
    chk("full_pc_ready_req", bus.pc_save_ready, 0);
    tick();
    bus.in_valid = 1'b0; bus.pc_save_valid = 1'b0;
    neg();
    chk("full_count_held", count, 4);
    tick();
    wb_stall = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      neg();
      chk("drain_wr", {bus.write_enable, bus.write_addr, bus.write_data}, {1'b1, 4'(i), 16'(16'hA0 + i)});
    end
    tick();
    neg();
    chk("drain_we_off", bus.write_enable, 0);
    chk("drain_empty", empty, 1);

    // PC save waits while count == DEPTH-1
    tick();
    wb_stall = 1'b1;
    for (int i = 1; i <= 3; i++) send(4'(i), 16'(16'hB0 + i));
    bus.pc_save_valid = 1'b1; bus.pc_save_value = 32'h5678_9ABC;
    neg();
    chk("pcwait_ready", bus.pc_save_ready, 0);
    chk("pcwait_in_ready", bus.in_ready, 0);
    chk("pcwait_count", count, 3);
    tick();
    wb_stall = 1'b0;
    neg();
    chk("pcwait_count_held", count, 3);
    chk("pcwait_ready2", bus.pc_save_ready, 0);
    tick();
    neg();
    chk("pcwait_ready3", bus.pc_save_ready, 1);
    expect_wr(4'd9, 16'h9ABC);
    expect_wr(4'd10, 16'h5678);
    tick();
    bus.pc_save_valid = 1'b0;
    repeat (6) tick();
    neg();
    chk("pcwait_empty", empty, 1);

    // Forwarding: youngest queue entry, then output register
    tick();
    wb_stall = 1'b1;
    send(4'd5, 16'h1111);
    send(4'd5, 16'h2222);
    bus.fwd_addr = 4'd5;
    #1;
    chk("fwd5_hit", bus.fwd_hit, 1);
    chk("fwd5_data", bus.fwd_data, 16'h2222);
    bus.fwd_addr = 4'd6;
    #1;
    chk("fwd6_hit", bus.fwd_hit, 0);
    chk("fwd6_data", bus.fwd_data, 0);
    bus.fwd_addr = 4'd5;
    wb_stall = 1'b0;
    tick();
    neg();
    chk("fwd_queue_over_out", {bus.fwd_hit, bus.fwd_data}, {1'b1, 16'h2222});
    tick();
    neg();
    chk("fwd_out_reg", {bus.fwd_hit, bus.fwd_data}, {1'b1, 16'h2222});
    tick();
    neg();
    chk("fwd_gone", {bus.fwd_hit, bus.fwd_data}, {1'b0, 16'h0000});

    // Flush with output register busy and a result request present
    tick();
    wb_stall = 1'b1;
    send(4'd11, 16'h00C1);
    send(4'd12, 16'h00C2);
    send(4'd13, 16'h00C3);
    wb_stall = 1'b0;
    tick();
    flush = 1'b1;
    bus.in_valid = 1'b1; bus.in_addr = 4'd14; bus.in_data = 16'h00C4;
    neg();
    chk("flush_in_ready", bus.in_ready, 0);
    chk("flush_pc_ready", bus.pc_save_ready, 0);
    #1;
    exp_q.delete();
    tick();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    neg();
    chk("flush_count", count, 0);
    chk("flush_we", bus.write_enable, 0);
    chk("flush_empty", empty, 1);
    repeat (4) tick();

    // Asynchronous reset mid-drain
    wb_stall = 1'b1;
    send(4'd1, 16'h00D1);
    send(4'd2, 16'h00D2);
    send(4'd3, 16'h00D3);
    wb_stall = 1'b0;
    bus.fwd_addr = 4'd1;
    tick();
    neg();
    #2;
    rst = 1'b0;
    #1;
    chk("arst_we", bus.write_enable, 0);
    chk("arst_waddr", bus.write_addr, 0);
    chk("arst_wdata", bus.write_data, 0);
    chk("arst_count", count, 0);
    chk("arst_empty", empty, 1);
    chk("arst_fwd_hit", bus.fwd_hit, 0);
    exp_q.delete();
    #1;
    rst = 1'b1;
    repeat (5) tick();
    neg();
    chk("final_empty", empty, 1);
    chk("final_pending", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_write_sequencer.md
Name: wb_write_sequencer

Overview:
- Write-back sequencer on the producer side of the register file.
- Queues results from the execute/memory stages and 32-bit PC save requests. Drains them one 16-bit write per cycle onto the register file write port (write_enable/write_addr/write_data).
- A PC save is split into two writes: low half to R9, high half to R10.
- Exposes a forwarding lookup so readers see values still pending, not yet committed.

Parameters:
DEPTH, 4, queue entries; must be >= 2
DATA_W, 16, register data width
ADDR_W, 4, register address width
PC_LO_ADDR, 9, destination of PC[15:0]
PC_HI_ADDR, 10, destination of PC[31:16]

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
flush  input  1  synchronous queue discard
wb_stall  input  1  hold: no pop this cycle
in_valid  input  1  result write request
in_ready  output  1  result write accepted when in_valid && in_ready
in_addr  input  ADDR_W  result destination register
in_data  input  DATA_W  result value
pc_save_valid  input  1  PC save request
pc_save_ready  output  1  PC save accepted when pc_save_valid && pc_save_ready
pc_save_value  input  32  PC to save
write_enable  output  1  registered register-file write strobe
write_addr  output  ADDR_W  registered write address
write_data  output  DATA_W  registered write data
fwd_addr  input  ADDR_W  forwarding lookup address
fwd_hit  output  1  pending write exists for fwd_addr
fwd_data  output  DATA_W  youngest pending value for fwd_addr, 0 if no hit
count  output  $clog2(DEPTH+1)  entries held in queue
empty  output  1  count == 0

Behaviour:

Reset (rst low, asynchronous):
- count = 0; head and tail pointers = 0.
- write_enable = 0, write_addr = 0, write_data = 0.
- fwd_hit = 0.

Queue:
- Circular buffer of {addr, data}. Pointers wrap modulo DEPTH.

Readiness (combinational, from registered count only; no pop-through credit):
- in_ready = !flush && !pc_save_valid && count <= DEPTH-1.
- pc_save_ready = !flush && count <= DEPTH-2.
- PC save has priority over a result write in the same cycle.

Push on rising edge:
- Result accept: push one entry {in_addr, in_data}.
- PC save accept: push two entries in order: {PC_LO_ADDR, value[15:0]}, then {PC_HI_ADDR, value[31:16]}. Low half always commits first.

Pop on rising edge:
- Condition: count_before_edge > 0, !wb_stall, !flush.
- Head moves into write_addr/write_data; write_enable <= 1.
- Otherwise write_enable <= 0; write_addr/write_data hold their values.

Count and latency:
- Same-edge push and pop are allowed: count_next = count + pushed - popped, where pushed is 0/1/2 and popped is 0/1.
- Latency with empty queue and no stall: accepted at edge N, popped at edge N+1, write_enable high for the cycle after edge N+1, regfile commits at edge N+2.
- Entries drain strictly in FIFO order, one per unstalled cycle.

Flush (synchronous, highest priority after reset):
- On the edge: count = 0, pointers = 0, write_enable <= 0.
- Pushes and pops that cycle are discarded.
- The entry already in the output register at that edge is not emitted again.

Forwarding (combinational):
- Search all valid queue entries plus the output register (when write_enable = 1) for addr == fwd_addr.
- Youngest match wins: tail-most queue entry beats older entries, and any queue entry beats the output register.
- No match: fwd_hit = 0, fwd_data = 0.

Boundaries and error behaviour:
- Full: requests held off via ready; no overwrite.
- Stall held indefinitely: queue contents and count are frozen apart from pushes.
- A PC save arriving with count == DEPTH-1 waits until a pop frees space.
- A request without its ready does not change any state.

Test Plan:
1. Reset mid-drain: 3 entries queued, write_enable high, rst pulsed low between edges -> immediately write_enable=0, write_addr=0, write_data=0, count=0, empty=1; the 3 entries are never written.
2. Single write: in addr=3, data=0x1234 accepted at edge N, queue empty, no stall -> write_enable=1, write_addr=3, write_data=0x1234 for exactly one cycle after edge N+1; count returns to 0.
3. PC save: pc_save_value=0x0001ABCD with in_valid also high -> in_ready=0; two consecutive write cycles (9, 0xABCD) then (10, 0x0001); the result write is accepted the cycle after.
4. Full/stall, DEPTH=4:
   - wb_stall=1; push four results with addrs 1..4 and data 0xA1..0xA4 -> count=4, in_ready=0, pc_save_ready=0, write_enable stays 0.
   - Release stall -> writes 1..4 in order on four consecutive cycles.
5. Forwarding: with stall, push (5, 0x1111) then (5, 0x2222), set fwd_addr=5 -> fwd_hit=1, fwd_data=0x2222; fwd_addr=6 -> fwd_hit=0, fwd_data=0.
6. Flush: 3 entries queued; flush=1 for one cycle with in_valid=1 -> count=0 and write_enable=0 after the edge, the pushed entry is dropped, and no writes appear afterward.
